hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns both HI/LO registers. It drives their write enables and write data.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
- Runs a 32-step shift-add multiply or restoring divide, then commits the results.
- Raises Stall so MFHI/MFLO in decode wait for a pending result.

Parameters:
- ITER, 32, iteration count; operand width fixed at 32; only 32 is supported.

Ports:
- Clk  input  1  clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  op valid this cycle; sampled only in IDLE
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x NOP
- OperandA  input  32  multiplicand / dividend / MTHI-MTLO source (rs)
- OperandB  input  32  multiplier / divisor (rt)
- ReadHiLo  input  1  MFHI/MFLO present in decode
- Busy  output  1  operation in flight
- Stall  output  1  combinational: ReadHiLo & Busy
- Done  output  1  one-cycle pulse in the commit cycle
- HiWriteEnable  output  1  to HI register WriteEnable
- LoWriteEnable  output  1  to LO register WriteEnable
- HiDataOut  output  32  to HI register dataIn
- LoDataOut  output  32  to LO register dataIn

Behaviour:
- Clock and reset: Clk, all state on posedge. Reset is synchronous, active-high.
- Reset values: Busy 0, Done 0, both write enables 0, HiDataOut 0, LoDataOut 0, state IDLE, counter 0. Reset mid-operation aborts with no write enable ever asserted.
- States: IDLE, MUL, DIV, FIX, WRITE.
- IDLE, Start=1 with Op 000-011:
  - Latch |A| and |B|: magnitudes for signed ops, raw values for unsigned.
  - Latch sign flags.
  - Clear the 64-bit accumulator and the counter.
  - Go to MUL or DIV.
- IDLE, Start=1 with MTHI/MTLO: go to WRITE with only the matching enable; data = OperandA. Cycle 1: enable=1, Done=1; Busy stays 0.
- IDLE, Start=1 with a NOP opcode: ignored.
- Start while Busy=1: ignored, no queuing.
- Cycle numbering: cycle k = k-th cycle after the acceptance edge.
- MUL: one multiplier bit per cycle (LSB first, add-shift). After ITER cycles go to FIX.
- DIV: restoring, one quotient bit per cycle (MSB first). After ITER cycles go to FIX.
- FIX (one cycle):
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; remainder takes the dividend's sign.
- WRITE:
  - HiWriteEnable=LoWriteEnable=1 and Done=1 for exactly one cycle.
  - Hi = product[63:32] / remainder; Lo = product[31:0] / quotient.
  - Next state IDLE.
- Latency for mul/div ops: cycles 1-32 iterate, cycle 33 FIX, cycle 34 WRITE. Busy=1 during cycles 1-34 and 0 at cycle 35. A new Start is accepted in cycle 35.
- Divide by zero: no trap, same latency. HI = OperandA as presented, LO = 0xFFFFFFFF. Applies to DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (32-bit wrap, no exception).
- HiDataOut/LoDataOut are registered and hold their last values outside WRITE. Enables are low outside WRITE.

Optional Feature:
- Macro HILO_EARLY_TERM_EN.
- Defined:
  - In MUL, go to FIX after the cycle in which the remaining shifted multiplier becomes zero, or after ITER cycles, whichever is first.
  - Iterations = max(1, index of highest set bit of |B| + 1).
  - WRITE occurs at cycle iterations+2.
  - DIV is unaffected.
- Not defined: fixed 32 iterations; WRITE at cycle 34 for all mul/div ops.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> cycle 34: HI=0xFFFFFFFE, LO=0x00000001, both enables and Done high one cycle; Busy low at cycle 35.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. With HILO_EARLY_TERM_EN: WRITE at cycle 5.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/0 -> HI=100, LO=0xFFFFFFFF, cycle 34.
- MTLO A=0x12345678 -> cycle 1: LoWriteEnable=1, HiWriteEnable=0, LoDataOut=0x12345678, Busy stays 0.
- Stall and Start while Busy: ReadHiLo=1 held during a DIVU -> Stall=1 cycles 1-34, 0 at cycle 35. A second Start (MTHI) at cycle 10 -> ignored, no extra enable pulse.
- Reset at cycle 20 of a MULT -> next cycle Busy=0, state IDLE, no write enable through cycle 40; a fresh MULTU 3x5 then gives LO=15, HI=0.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative 32-step multiply / restoring-divide sequencer that owns the HI/LO write ports.
// Optional macro HILO_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are zero.
module hilo_muldiv_ctrl #(
    parameter int ITER = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    input  logic        ReadHiLo,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic        HiWriteEnable,
    output logic        LoWriteEnable,
    output logic [31:0] HiDataOut,
    output logic [31:0] LoDataOut,
    output logic [2:0]  DebugState
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_FIX   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [5:0] LAST = 6'(ITER - 1);

    state_t      r_state, w_next;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [63:0] r_mcand;
    logic [31:0] r_opb;
    logic        r_neg_res, r_neg_rem, r_bzero, r_is_div;
    logic        r_mt_op, r_wr_hi, r_wr_lo;
    logic [31:0] r_hi_data, r_lo_data;

    // Start is a valid whose implicit ready is (state == IDLE); a Start seen in any other state is dropped.
    logic w_accept_md, w_accept_mt;
    assign w_accept_md = Start && (r_state == S_IDLE) && !Op[2];
    assign w_accept_mt = Start && (r_state == S_IDLE) && (Op[2:1] == 2'b10);

    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    assign w_a_neg = !Op[0] && OperandA[31];
    assign w_b_neg = !Op[0] && OperandB[31];
    assign w_a_mag = w_a_neg ? -OperandA : OperandA;
    assign w_b_mag = w_b_neg ? -OperandB : OperandB;

    logic w_mul_early;
`ifdef HILO_EARLY_TERM_EN
    assign w_mul_early = (r_opb[31:1] == 31'd0);
`else
    assign w_mul_early = 1'b0;
`endif

    // Restoring divide step: r_acc[63:32] is the partial remainder, r_acc[31:0] dividend/quotient.
    logic [32:0] w_div_shift;
    logic [33:0] w_div_diff;
    logic [63:0] w_div_acc;
    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opb};
    assign w_div_acc   = w_div_diff[33] ? {w_div_shift[31:0], r_acc[30:0], 1'b0}
                                        : {w_div_diff[31:0], r_acc[30:0], 1'b1};

    logic [63:0] w_prod;
    logic [31:0] w_quo, w_rem, w_fix_hi, w_fix_lo;
    assign w_prod   = r_neg_res ? -r_acc : r_acc;
    assign w_quo    = r_bzero ? 32'hFFFF_FFFF : (r_neg_res ? -r_acc[31:0] : r_acc[31:0]);
    assign w_rem    = r_neg_rem ? -r_acc[63:32] : r_acc[63:32];
    assign w_fix_hi = r_is_div ? w_rem : w_prod[63:32];
    assign w_fix_lo = r_is_div ? w_quo : w_prod[31:0];

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_md)      w_next = Op[1] ? S_DIV : S_MUL;
                else if (w_accept_mt) w_next = S_WRITE;
            end
            S_MUL:   if (r_cnt == LAST || w_mul_early) w_next = S_FIX;
            S_DIV:   if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:   w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy          = (r_state != S_IDLE) && !r_mt_op;
        Stall         = ReadHiLo && Busy;
        Done          = (r_state == S_WRITE);
        HiWriteEnable = (r_state == S_WRITE) && r_wr_hi;
        LoWriteEnable = (r_state == S_WRITE) && r_wr_lo;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt     <= 6'd0;
            r_acc     <= 64'd0;
            r_mcand   <= 64'd0;
            r_opb     <= 32'd0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_bzero   <= 1'b0;
            r_is_div  <= 1'b0;
            r_mt_op   <= 1'b0;
            r_wr_hi   <= 1'b0;
            r_wr_lo   <= 1'b0;
            r_hi_data <= 32'd0;
            r_lo_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mt_op <= w_accept_mt;
                    if (w_accept_md) begin
                        r_cnt     <= 6'd0;
                        r_acc     <= Op[1] ? {32'd0, w_a_mag} : 64'd0;
                        r_mcand   <= {32'd0, w_a_mag};
                        r_opb     <= w_b_mag;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_bzero   <= (OperandB == 32'd0);
                        r_is_div  <= Op[1];
                        r_wr_hi   <= 1'b1;
                        r_wr_lo   <= 1'b1;
                    end else if (w_accept_mt) begin
                        r_wr_hi <= !Op[0];
                        r_wr_lo <= Op[0];
                        if (Op[0]) r_lo_data <= OperandA;
                        else       r_hi_data <= OperandA;
                    end
                end
                S_MUL: begin
                    r_cnt   <= r_cnt + 6'd1;
                    if (r_opb[0]) r_acc <= r_acc + r_mcand;
                    r_mcand <= r_mcand << 1;
                    r_opb   <= r_opb >> 1;
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_acc <= w_div_acc;
                end
                S_FIX: begin
                    r_hi_data <= w_fix_hi;
                    r_lo_data <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign HiDataOut  = r_hi_data;
    assign LoDataOut  = r_lo_data;
    assign DebugState = r_state;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: vector table plus hand sequences for stall, ignored start and reset abort.
module tb_hilo_muldiv_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Start, ReadHiLo;
    logic [2:0]  Op;
    logic [31:0] OperandA, OperandB;
    logic        Busy, Stall, Done, HiWriteEnable, LoWriteEnable;
    logic [31:0] HiDataOut, LoDataOut;
    logic [2:0]  DebugState;

    hilo_muldiv_ctrl #(.ITER(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB), .ReadHiLo(ReadHiLo),
        .Busy(Busy), .Stall(Stall), .Done(Done),
        .HiWriteEnable(HiWriteEnable), .LoWriteEnable(LoWriteEnable),
        .HiDataOut(HiDataOut), .LoDataOut(LoDataOut), .DebugState(DebugState)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        int          cyc_et;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          exp_cyc;
        int          k;
        logic        exp_hwe, exp_lwe, exp_busy;
        logic [31:0] eh, el;
`ifdef HILO_EARLY_TERM_EN
        exp_cyc = v.cyc_et;
`else
        exp_cyc = v.cyc;
`endif
        exp_hwe  = (v.op != 3'b101);
        exp_lwe  = (v.op != 3'b100);
        exp_busy = !v.op[2];
        exp_q.push_back(v.hi);
        exp_q.push_back(v.lo);
        @(negedge Clk);
        Start = 1'b1; Op = v.op; OperandA = v.a; OperandB = v.b;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 3'b110;
        check($sformatf("v%0d busy_c1", idx), {31'd0, Busy}, {31'd0, exp_busy});
        k = 1;
        while (!Done && k < 40) begin
            @(posedge Clk); #1;
            k++;
        end
        eh = exp_q.pop_front();
        el = exp_q.pop_front();
        check($sformatf("v%0d write_cycle", idx), 32'(k), 32'(exp_cyc));
        check($sformatf("v%0d done", idx), {31'd0, Done}, 32'd1);
        check($sformatf("v%0d hi_we", idx), {31'd0, HiWriteEnable}, {31'd0, exp_hwe});
        check($sformatf("v%0d lo_we", idx), {31'd0, LoWriteEnable}, {31'd0, exp_lwe});
        check($sformatf("v%0d hi", idx), HiDataOut, eh);
        check($sformatf("v%0d lo", idx), LoDataOut, el);
        @(posedge Clk); #1;
        check($sformatf("v%0d busy_after", idx), {31'd0, Busy}, 32'd0);
        check($sformatf("v%0d done_after", idx), {31'd0, Done}, 32'd0);
        check($sformatf("v%0d we_after", idx), {30'd0, HiWriteEnable, LoWriteEnable}, 32'd0);
        check($sformatf("v%0d hi_hold", idx), HiDataOut, eh);
        check($sformatf("v%0d lo_hold", idx), LoDataOut, el);
    endtask

    initial begin
        int hwe_pulses;
        int lwe_pulses;
        int done_pulses;
        vec_t v_fresh;

        vecs[0]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 34};
        vecs[1]  = '{3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 5};
        vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 34};
        vecs[3]  = '{3'b011, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 34, 34};
        vecs[4]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 34};
        vecs[5]  = '{3'b101, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1, 1};
        vecs[6]  = '{3'b100, 32'hCAFE_BABE, 32'h0000_0000, 32'hCAFE_BABE, 32'h1234_5678, 1, 1};
        vecs[7]  = '{3'b000, 32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 4};
        vecs[8]  = '{3'b001, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 34, 3};
        vecs[9]  = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 34};
        vecs[10] = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 34, 34};
        vecs[11] = '{3'b001, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 34, 4};
        vecs[12] = '{3'b011, 32'd1000,      32'd7,         32'd6,         32'd142,       34, 34};

        // clock/reset
        Reset = 1'b1; Start = 1'b0; ReadHiLo = 1'b0; Op = 3'b110;
        OperandA = 32'd0; OperandB = 32'd0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst busy", {31'd0, Busy}, 32'd0);
        check("rst done", {31'd0, Done}, 32'd0);
        check("rst we", {30'd0, HiWriteEnable, LoWriteEnable}, 32'd0);
        check("rst hi", HiDataOut, 32'd0);
        check("rst lo", LoDataOut, 32'd0);
        check("rst state", {29'd0, DebugState}, 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Stall across a DIVU; a MTHI offered mid-operation must be dropped.
        ReadHiLo = 1'b1;
        hwe_pulses = 0;
        lwe_pulses = 0;
        @(negedge Clk);
        Start = 1'b1; Op = 3'b011; OperandA = 32'd100; OperandB = 32'd7;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 3'b110;
        for (int k = 1; k <= 35; k++) begin
            check($sformatf("stall c%0d", k), {31'd0, Stall}, (k <= 34) ? 32'd1 : 32'd0);
            if (HiWriteEnable) hwe_pulses++;
            if (LoWriteEnable) lwe_pulses++;
            if (k == 34) begin
                check("stall_seq done", {31'd0, Done}, 32'd1);
                check("stall_seq hi", HiDataOut, 32'd2);
                check("stall_seq lo", LoDataOut, 32'd14);
            end
            if (k == 10) begin
                Start = 1'b1; Op = 3'b100; OperandA = 32'hDEAD_BEEF;
            end
            if (k == 11) begin
                Start = 1'b0; Op = 3'b110;
            end
            if (k < 35) begin
                @(posedge Clk); #1;
            end
        end
        check("stall_seq hi pulses", 32'(hwe_pulses), 32'd1);
        check("stall_seq lo pulses", 32'(lwe_pulses), 32'd1);
        check("stall_seq hi kept", HiDataOut, 32'd2);
        ReadHiLo = 1'b0;

        // NOP opcode in IDLE is ignored.
        done_pulses = 0;
        @(negedge Clk);
        Start = 1'b1; Op = 3'b111; OperandA = 32'h5555_5555;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 3'b110;
        for (int k = 1; k <= 5; k++) begin
            if (Done || Busy || HiWriteEnable || LoWriteEnable) done_pulses++;
            if (k < 5) begin
                @(posedge Clk); #1;
            end
        end
        check("nop activity", 32'(done_pulses), 32'd0);
        check("nop state", {29'd0, DebugState}, 32'd0);

        // Reset at cycle 20 of a MULT aborts with no write.
        @(negedge Clk);
        Start = 1'b1; Op = 3'b000; OperandA = 32'd3; OperandB = 32'h4000_0000;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 3'b110;
        for (int k = 1; k < 20; k++) begin
            @(posedge Clk); #1;
        end
        check("abort busy c20", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("abort busy c21", {31'd0, Busy}, 32'd0);
        check("abort state c21", {29'd0, DebugState}, 32'd0);
        check("abort done c21", {31'd0, Done}, 32'd0);
        check("abort hi c21", HiDataOut, 32'd0);
        check("abort lo c21", LoDataOut, 32'd0);
        hwe_pulses = 0;
        for (int k = 21; k <= 40; k++) begin
            if (HiWriteEnable || LoWriteEnable || Done) hwe_pulses++;
            if (k < 40) begin
                @(posedge Clk); #1;
            end
        end
        check("abort no write", 32'(hwe_pulses), 32'd0);
        v_fresh = '{3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 34, 5};
        run_vec(99, v_fresh);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
